// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants, position/state types and width helper for the I2S clock generator.
package i2s_pkg;
    localparam int I2S_MCLK_HZ      = 38_400_000;
    localparam int I2S_DEF_HALF_DIV = 75;

    typedef struct packed {
        logic [3:0] slot;
        logic [4:0] bit_pos;
    } i2s_pos_t;

    typedef enum logic {
        IDLE,
        RUN
    } i2s_clk_state_e;

    // Counter width with a floor of one bit so degenerate ranges still get a flop.
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/i2s_edge_div.sv
// i2s_edge_div: half-period counter and SCLK toggle flop with registered edge strobes.
module i2s_edge_div
    import i2s_pkg::*;
#(
    parameter int HALF_DIV = I2S_DEF_HALF_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic sclk_out,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic fall_next
);
    localparam int DW = clog2_min1(HALF_DIV);

    logic [DW-1:0] div_ctr_q, div_ctr_d;
    logic sclk_q, sclk_d, rise_q, rise_d, fall_q, fall_d, tc;

    // Dropping enable clears everything, so a stop beats a coincident terminal count.
    always_comb begin
        tc        = enable && (div_ctr_q == DW'(HALF_DIV - 1));
        div_ctr_d = (!enable || tc) ? '0 : div_ctr_q + 1'b1;
        sclk_d    = enable && (sclk_q ^ tc);
        rise_d    = tc && !sclk_q;
        fall_d    = tc && sclk_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_ctr_q <= '0;
            sclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            div_ctr_q <= div_ctr_d;
            sclk_q    <= sclk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign fall_next = fall_d;
    assign sclk_out  = sclk_q;
    assign sclk_rise = rise_q;
    assign sclk_fall = fall_q;
endmodule

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: I2S/TDM SCLK and WS generator with edge strobes and slot/bit indices.
// Define I2S_CLKGEN_TDM_EN for TDM (2..16 slots, one-SCLK frame-sync WS); default is I2S stereo.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int HALF_DIV  = I2S_DEF_HALF_DIV,
    parameter int SLOT_BITS = 16,
    parameter int SLOTS     = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    output logic                               sclk_out,
    output logic                               ws_out,
    output logic                               sclk_rise,
    output logic                               sclk_fall,
    output logic                               frame_start,
    output logic [clog2_min1(SLOTS)-1:0]       slot_idx,
    output logic [clog2_min1(SLOT_BITS)-1:0]   bit_idx
);
    localparam int SW = clog2_min1(SLOTS);
    localparam int BW = clog2_min1(SLOT_BITS);

`ifdef I2S_CLKGEN_TDM_EN
    if (SLOTS < 2 || SLOTS > 16) begin : g_slots_chk
        $error("i2s_clk_gen: SLOTS must be 2..16 in TDM mode");
    end
`else
    if (SLOTS != 2) begin : g_slots_chk
        $error("i2s_clk_gen: SLOTS must be 2 without I2S_CLKGEN_TDM_EN");
    end
`endif
    if (HALF_DIV < 2 || HALF_DIV > 255 || SLOT_BITS < 2 || SLOT_BITS > 32) begin : g_par_chk
        $error("i2s_clk_gen: HALF_DIV or SLOT_BITS out of range");
    end

    i2s_clk_state_e state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [BW-1:0] bit_q, bit_d;
    logic ws_q, ws_d, fs_q, fs_d;
    logic run, start, fall_next, bit_wrap, slot_wrap;

    i2s_edge_div #(.HALF_DIV(HALF_DIV)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (run),
        .sclk_out  (sclk_out),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .fall_next (fall_next)
    );

    // Indices and WS are computed from next-state values so they land on the sclk_fall edge.
    always_comb begin
        run       = (state_q == RUN) && enable;
        start     = (state_q == IDLE) && enable;
        state_d   = enable ? RUN : IDLE;
        bit_wrap  = bit_q == BW'(SLOT_BITS - 1);
        slot_wrap = slot_q == SW'(SLOTS - 1);
        bit_d     = !run ? '0 : !fall_next ? bit_q : bit_wrap ? '0 : bit_q + 1'b1;
        slot_d    = !run ? '0 : !(fall_next && bit_wrap) ? slot_q : slot_wrap ? '0 : slot_q + 1'b1;
        fs_d      = start || (run && fall_next && bit_wrap && slot_wrap);
`ifdef I2S_CLKGEN_TDM_EN
        ws_d      = (start || run) && slot_d == '0 && bit_d == '0;
`else
        ws_d      = run && slot_d == SW'(1);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            bit_q   <= '0;
            ws_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            ws_q    <= ws_d;
            fs_q    <= fs_d;
        end
    end

    assign ws_out      = ws_q;
    assign frame_start = fs_q;
    assign slot_idx    = slot_q;
    assign bit_idx     = bit_q;
endmodule

// File: tb/tb_i2s_clk_gen.sv
// tb_i2s_clk_gen: randomized enable/reset stimulus scored against an arithmetic timing model.
module tb_i2s_clk_gen;
    localparam int H  = 3;
    localparam int SB = 4;
`ifdef I2S_CLKGEN_TDM_EN
    localparam int NS = 4;
`else
    localparam int NS = 2;
`endif
    localparam int SW = $clog2(NS);
    localparam int BW = $clog2(SB);
    localparam int FRAME = 2 * H * SB * NS;

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic sclk_out, ws_out, sclk_rise, sclk_fall, frame_start;
    logic [SW-1:0] slot_idx;
    logic [BW-1:0] bit_idx;

    i2s_clk_gen #(.HALF_DIV(H), .SLOT_BITS(SB), .SLOTS(NS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .sclk_out    (sclk_out),
        .ws_out      (ws_out),
        .sclk_rise   (sclk_rise),
        .sclk_fall   (sclk_fall),
        .frame_start (frame_start),
        .slot_idx    (slot_idx),
        .bit_idx     (bit_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sclk, ws, rise, fall, fs;
        logic [SW-1:0] slot;
        logic [BW-1:0] bpos;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    bit running = 0;
    int t = 0;

    // t counts clk cycles since the first RUN cycle; everything follows from it.
    function automatic exp_t model(input bit run, input int tt);
        exp_t e = '0;
        int p;
        if (!run) return e;
        p = tt / (2 * H);
        e.sclk = ((tt / H) % 2) == 1;
        e.rise = tt > 0 && tt % H == 0 && (tt / H) % 2 == 1;
        e.fall = tt > 0 && tt % H == 0 && (tt / H) % 2 == 0;
        e.bpos = BW'(p % SB);
        e.slot = SW'((p / SB) % NS);
        e.fs   = tt % FRAME == 0;
`ifdef I2S_CLKGEN_TDM_EN
        e.ws   = e.slot == '0 && e.bpos == '0;
`else
        e.ws   = e.slot == SW'(1);
`endif
        return e;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running = 0;
            t = 0;
            q.delete();
        end else if (enable) begin
            t = running ? t + 1 : 0;
            running = 1;
        end else begin
            running = 0;
        end
        q.push_back(model(running, t));
    end

    always @(negedge clk) begin
        exp_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {sclk_out, ws_out, sclk_rise, sclk_fall, frame_start, slot_idx, bit_idx};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs @%0t got sclk=%b ws=%b rise=%b fall=%b fs=%b slot=%0d bit=%0d exp sclk=%b ws=%b rise=%b fall=%b fs=%b slot=%0d bit=%0d",
                         $time, a.sclk, a.ws, a.rise, a.fall, a.fs, a.slot, a.bpos,
                         e.sclk, e.ws, e.rise, e.fall, e.fs, e.slot, e.bpos);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #2 enable = 1'b1;
        repeat (3 * FRAME + 5) @(posedge clk);
        #2 enable = 1'b0;
        repeat (4) @(posedge clk);
        // Drop enable exactly in the terminal-count cycle of the first rise, then the first fall.
        for (int k = 1; k <= 2; k++) begin
            #2 enable = 1'b1;
            repeat (k * H) @(posedge clk);
            #2 enable = 1'b0;
            repeat (3) @(posedge clk);
        end
        for (int i = 0; i < 30; i++) begin
            #2 enable = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 70)) @(posedge clk);
        end
        #2 enable = 1'b1;
        repeat (40) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({sclk_out, ws_out, sclk_rise, sclk_fall, frame_start, slot_idx, bit_idx} !== '0) begin
            errors++;
            $display("FAIL async_reset got sclk=%b ws=%b rise=%b fall=%b fs=%b slot=%0d bit=%0d exp all zero",
                     sclk_out, ws_out, sclk_rise, sclk_fall, frame_start, slot_idx, bit_idx);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (2 * FRAME) @(posedge clk);
        #2 enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_clk_gen.md
# i2s_clk_gen

Parametrised I2S/TDM bit-clock and word-select generator for the audio front end. It divides the master clock `clk` (38.4 MHz) into SCLK and produces WS with a configurable number of bits per slot and slots per frame. It also provides single-cycle SCLK edge strobes, a frame-start strobe and slot/bit position indices, so serialisers and deserialisers in the `clk` domain never need to edge-detect SCLK.

## Interface
Parameters:
- `HALF_DIV`, default 75: `clk` cycles per SCLK half-period, so SCLK period = 2·HALF_DIV; legal range 2..255.
- `SLOT_BITS`, default 16: SCLK periods per slot; legal range 2..32.
- `SLOTS`, default 2: slots per frame; must be 2 unless `I2S_CLKGEN_TDM_EN` is defined, then 2..16.

Ports:
- `clk` input 1: master clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: run when high; idle and re-arm when low.
- `sclk_out` output 1: bit clock.
- `ws_out` output 1: word select or frame sync.
- `sclk_rise` output 1: one-cycle strobe, high in the cycle `sclk_out` becomes 1.
- `sclk_fall` output 1: one-cycle strobe, high in the cycle `sclk_out` becomes 0.
- `frame_start` output 1: one-cycle strobe at slot 0, bit 0.
- `slot_idx` output $clog2(SLOTS): current slot.
- `bit_idx` output $clog2(SLOT_BITS): current bit within the slot; 0 = MSB.

## Operation
- All outputs are registered and reset to 0.
- State machine has two states:
  - IDLE: all counters are 0, `sclk_out`=0, `ws_out`=0, strobes are 0.
  - IDLE→RUN on `enable`=1.
  - RUN→IDLE in the first cycle `enable` is sampled 0. Outputs return to idle values on the next edge, with no partial-frame completion.
- Divider: `div_ctr` counts 0..HALF_DIV-1 and wraps. The terminal count toggles `sclk_out` and fires the matching strobe on the same edge.
- Position counters advance only on SCLK falling edges:
  - `bit_idx` wraps SLOT_BITS-1→0 and increments `slot_idx`.
  - `slot_idx` wraps SLOTS-1→0.
  - Counter widths are $clog2(·), with a minimum of 1 bit.
- `frame_start` fires in the first RUN cycle and on every falling edge where both indices wrap to 0.
- Without TDM, `ws_out` = (`slot_idx` == 1). It updates on the same edge as `sclk_fall`, giving 50% duty, left-justified framing.
- Re-enable always restarts at slot 0, bit 0 with SCLK low.

## Timing
- The first `sclk_rise` occurs HALF_DIV cycles after the first RUN cycle. The first `sclk_fall` occurs 2·HALF_DIV cycles after it.
- `sclk_rise` and `sclk_fall` are never high together. Each is exactly one `clk` cycle wide.
- Indices and `ws_out` change only in `sclk_fall` cycles, plus the first RUN cycle. Consumers sample data on `sclk_rise`.
- Frame length is 2·HALF_DIV·SLOT_BITS·SLOTS `clk` cycles. The default is 4800 cycles, which is 8 kHz at 38.4 MHz.
- Dropping `enable` in the same cycle as a terminal count: the stop wins, and no strobe is issued on the following edge.
- Reset asserted mid-frame: all outputs go to 0 asynchronously, and the state returns to IDLE.

## Configuration
- Macro `I2S_CLKGEN_TDM_EN`.
- Defined:
  - `SLOTS` may be 2..16.
  - `ws_out` is a one-SCLK-period frame-sync pulse. It is high from the `frame_start` edge until the next `sclk_fall` (i.e. while `slot_idx`==0 and `bit_idx`==0), and low otherwise.
- Undefined:
  - I2S stereo mode only.
  - `SLOTS`≠2 is an elaboration-time `$error`.
  - `ws_out` is the L/R select described above.

## Structure
- Package `i2s_pkg` holds:
  - constants `I2S_MCLK_HZ` = 38_400_000 and `I2S_DEF_HALF_DIV` = 75;
  - typedef `i2s_pos_t`, a struct of slot and bit indices sized for the maximum 16 slots × 32 bits;
  - the state enum `i2s_clk_state_e` with values IDLE and RUN.
- One sub-module, `i2s_edge_div`: the half-period counter plus the SCLK toggle flop, producing `sclk_out`, `sclk_rise` and `sclk_fall`, with its own `enable` input.
- The top level owns the state machine, the position counters and WS generation.

## Test plan
- Defaults, `enable` high from reset release: the first `sclk_rise` comes 75 cycles after the first RUN cycle, and the SCLK period is 150 cycles. `ws_out` rises at the 16th `sclk_fall` and falls at the 32nd, and `frame_start` repeats every 4800 cycles.
- HALF_DIV=2, SLOT_BITS=4: `bit_idx` steps 0,1,2,3,0. `slot_idx` toggles every 16 cycles, and the strobes alternate every 2 cycles with no overlap.
- `enable` dropped at `bit_idx`=7, `slot_idx`=1: all outputs are 0 one cycle later. After re-enable, `frame_start` fires immediately with indices 0/0 and `ws_out`=0.
- `reset_n` pulsed low mid-slot: all outputs are 0 asynchronously. Operation resumes from frame start after release, provided `enable` is high.
- `I2S_CLKGEN_TDM_EN` with SLOTS=8, SLOT_BITS=32, HALF_DIV=2: the `ws_out` pulse is 4 cycles wide, once per 1024 cycles, aligned with `frame_start`, and `slot_idx` counts 0..7.
- `enable` dropped in the same cycle as the `div_ctr` terminal count: no strobe on the next edge, and `sclk_out` is forced to 0.
